// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding reads to
// instruction memory, and drives the IF/ID pipeline register with a one-word skid buffer.
module fetch_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     stall_d,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    WAIT_DROP,
    HOLD
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] pc_f;
  logic [DATA_WIDTH-1:0]    skid;
  logic                     running;

  logic                     ifid_free;
  logic                     req_fire;
  logic                     load_rsp;
  logic                     load_skid;
  logic                     load_ifid;
  logic [DATA_WIDTH-1:0]    load_word;
  logic [ADDRESS_WIDTH-1:0] pc_f_plus4;
  logic [ADDRESS_WIDTH-1:0] redirect_pc;
  logic                     unused_target_bits;

  // running keeps the request low until the first edge after reset release
  assign imem_req_valid = (state == ISSUE) && running;
  assign imem_addr      = pc_f;

  assign ifid_free   = !stall_d || !valid_d;
  assign req_fire    = imem_req_valid && imem_req_ready;
  assign load_rsp    = (state == WAIT) && imem_rsp_valid && ifid_free && !pc_src_e;
  assign load_skid   = (state == HOLD) && ifid_free && !pc_src_e;
  assign load_ifid   = load_rsp || load_skid;
  assign load_word   = (state == HOLD) ? skid : imem_rdata;
  assign pc_f_plus4  = pc_f + ADDRESS_WIDTH'(4);
  assign redirect_pc = {pc_target_e[ADDRESS_WIDTH-1:2], 2'b00};

  assign unused_target_bits = ^pc_target_e[1:0];

  // Fetch FSM, fetch PC and skid buffer; a redirect overrides everything else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ISSUE;
      pc_f    <= RESET_PC;
      skid    <= '0;
      running <= 1'b0;
    end else begin
      running <= 1'b1;
      if (pc_src_e) begin
        pc_f <= redirect_pc;
        case (state)
          ISSUE:     state <= req_fire ? WAIT_DROP : ISSUE;
          WAIT:      state <= imem_rsp_valid ? ISSUE : WAIT_DROP;
          WAIT_DROP: state <= imem_rsp_valid ? ISSUE : WAIT_DROP;
          HOLD:      state <= ISSUE;
          default:   state <= ISSUE;
        endcase
      end else begin
        case (state)
          ISSUE: begin
            if (req_fire) begin
              state <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              if (ifid_free) begin
                pc_f  <= pc_f_plus4;
                state <= ISSUE;
              end else begin
                skid  <= imem_rdata;
                state <= HOLD;
              end
            end
          end
          WAIT_DROP: begin
            if (imem_rsp_valid) begin
              state <= ISSUE;
            end
          end
          HOLD: begin
            if (ifid_free) begin
              pc_f  <= pc_f_plus4;
              state <= ISSUE;
            end
          end
          default: state <= ISSUE;
        endcase
      end
    end
  end

  // IF/ID register: flush beats load, load beats stall-hold, otherwise a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d    <= 1'b0;
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
    end else if (pc_src_e) begin
      valid_d <= 1'b0;
      instr_d <= NOP;
    end else if (load_ifid) begin
      valid_d    <= 1'b1;
      instr_d    <= load_word;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_f_plus4;
    end else if (!stall_d) begin
      valid_d <= 1'b0;
      instr_d <= NOP;
    end
  end

endmodule
